// File: rtl/kmeans_sequencer_if.sv
// Engine-facing bundle of the k-means iteration controller.
// master: the sequencer (drives addresses, clear, cluster select, means, status).
// slave : the environment (drives start, initial means and cluster readback).
interface kmeans_sequencer_if #(
    parameter int T  = 16,
    parameter int AW = 12
);
    localparam int CW = (T > 1) ? $clog2(T) : 1;

    logic              start;
    logic [24*T-1:0]   mean_init;
    logic [AW-1:0]     pix_addr;
    logic              pix_en;
    logic              acc_clear;
    logic [CW-1:0]     cl_idx;
    logic [19:0]       sum_r;
    logic [19:0]       sum_g;
    logic [19:0]       sum_b;
    logic [11:0]       count;
    logic [24*T-1:0]   means;
    logic              busy;
    logic              done;
    logic              converged;
    logic [7:0]        iter;

    modport master (
        input  start, mean_init, sum_r, sum_g, sum_b, count,
        output pix_addr, pix_en, acc_clear, cl_idx, means, busy, done, converged, iter
    );

    modport slave (
        output start, mean_init, sum_r, sum_g, sum_b, count,
        input  pix_addr, pix_en, acc_clear, cl_idx, means, busy, done, converged, iter
    );
endinterface

// File: rtl/kmeans_sequencer.sv
// K-means iteration controller: scan frame, drain engine, divide sums by counts, repeat.
// Ports: clk, reset (async active-low), bus (master modport of kmeans_sequencer_if).
// Per iteration NPIX + LAT + 22*T + 1 cycles; start is only honoured while idle.
module kmeans_sequencer #(
    parameter int T        = 16,
    parameter int NPIX     = 4096,
    parameter int AW       = 12,
    parameter int LAT      = 2,
    parameter int MAX_ITER = 8
) (
    input  logic clk,
    input  logic reset,
    kmeans_sequencer_if.master bus
);
    localparam int CW = (T > 1) ? $clog2(T) : 1;

    typedef enum logic [3:0] {
        IDLE, INIT, SCAN, DRAIN, LOAD, DIV, WRITE, CHECK, DONE
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       addr_q, addr_d;     // pixel address in SCAN, cycle count in DRAIN
    logic [4:0]          cnt_q, cnt_d;       // divider step
    logic [CW-1:0]       cl_idx_q, cl_idx_d;
    logic                changed_q, changed_d;
    logic [T-1:0][23:0]  means_q, means_d;
    logic [7:0]          iter_q, iter_d;
    logic                conv_q, conv_d;
    logic [11:0]         dvs_q, dvs_d;       // shared divisor (pixel count)
    logic [19:0]         dvd_q[3];           // dividend shifts out MSB-first, quotient shifts in
    logic [19:0]         dvd_d[3];
    logic [11:0]         rem_q[3];
    logic [11:0]         rem_d[3];
    logic [12:0]         rem_sh[3];
    logic [7:0]          iter_inc;
    logic [23:0]         new_mean;
    logic                pix_en, acc_clear, done;

    function automatic logic [7:0] sat8(input logic [19:0] q);
        return (q > 20'd255) ? 8'hFF : q[7:0];
    endfunction

    assign iter_inc = iter_q + 8'd1;
    assign new_mean = {sat8(dvd_q[0]), sat8(dvd_q[1]), sat8(dvd_q[2])};

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        cl_idx_d  = cl_idx_q;
        changed_d = changed_q;
        means_d   = means_q;
        iter_d    = iter_q;
        conv_d    = conv_q;
        dvs_d     = dvs_q;
        pix_en    = 1'b0;
        acc_clear = 1'b0;
        done      = 1'b0;
        for (int ch = 0; ch < 3; ch++) begin
            dvd_d[ch]  = dvd_q[ch];
            rem_d[ch]  = rem_q[ch];
            rem_sh[ch] = {rem_q[ch], dvd_q[ch][19]};
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    iter_d  = 8'd0;
                    conv_d  = 1'b0;
                    state_d = INIT;
                end
            end
            INIT: begin
                means_d   = bus.mean_init;
                acc_clear = 1'b1;
                addr_d    = '0;
                state_d   = SCAN;
            end
            SCAN: begin
                pix_en = 1'b1;
                if (addr_q == AW'(NPIX - 1)) begin
                    addr_d  = '0;
                    state_d = DRAIN;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            DRAIN: begin
                if (addr_q == AW'(LAT - 1)) begin
                    addr_d    = '0;
                    cl_idx_d  = '0;
                    changed_d = 1'b0;
                    state_d   = LOAD;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            LOAD: begin
                dvd_d[0] = bus.sum_r;
                dvd_d[1] = bus.sum_g;
                dvd_d[2] = bus.sum_b;
                dvs_d    = bus.count;
                for (int ch = 0; ch < 3; ch++) rem_d[ch] = '0;
                cnt_d    = '0;
                state_d  = DIV;
            end
            DIV: begin
                // Restoring step; remainder stays below the divisor so 12 bits suffice.
                // A zero divisor yields all-ones quotients, which WRITE discards.
                for (int ch = 0; ch < 3; ch++) begin
                    if (rem_sh[ch] >= {1'b0, dvs_q}) begin
                        rem_d[ch] = 12'(rem_sh[ch] - {1'b0, dvs_q});
                        dvd_d[ch] = {dvd_q[ch][18:0], 1'b1};
                    end else begin
                        rem_d[ch] = rem_sh[ch][11:0];
                        dvd_d[ch] = {dvd_q[ch][18:0], 1'b0};
                    end
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd19) state_d = WRITE;
            end
            WRITE: begin
                if (dvs_q != 12'd0) begin
                    if (new_mean != means_q[cl_idx_q]) changed_d = 1'b1;
                    means_d[cl_idx_q] = new_mean;
                end
                if (cl_idx_q == CW'(T - 1)) begin
                    state_d = CHECK;
                end else begin
                    cl_idx_d = cl_idx_q + 1'b1;
                    state_d  = LOAD;
                end
            end
            CHECK: begin
                iter_d = iter_inc;
                if (changed_q && (iter_inc < 8'(MAX_ITER))) begin
                    acc_clear = 1'b1;
                    addr_d    = '0;
                    state_d   = SCAN;
                end else begin
                    conv_d  = !changed_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            cl_idx_q  <= '0;
            changed_q <= 1'b0;
            means_q   <= '0;
            iter_q    <= 8'd0;
            conv_q    <= 1'b0;
            dvs_q     <= '0;
            for (int ch = 0; ch < 3; ch++) begin
                dvd_q[ch] <= '0;
                rem_q[ch] <= '0;
            end
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            cl_idx_q  <= cl_idx_d;
            changed_q <= changed_d;
            means_q   <= means_d;
            iter_q    <= iter_d;
            conv_q    <= conv_d;
            dvs_q     <= dvs_d;
            for (int ch = 0; ch < 3; ch++) begin
                dvd_q[ch] <= dvd_d[ch];
                rem_q[ch] <= rem_d[ch];
            end
        end
    end

    assign bus.pix_addr  = addr_q;
    assign bus.pix_en    = pix_en;
    assign bus.acc_clear = acc_clear;
    assign bus.cl_idx    = cl_idx_q;
    assign bus.means     = means_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done;
    assign bus.converged = conv_q;
    assign bus.iter      = iter_q;
endmodule
